fetch_sequencer: RTL and testbench

//  Sequences the 8-bit program counter register and the instruction-memory fetch.

---
 rtl/fetch_sequencer_if.sv | 39 +++
 rtl/fetch_sequencer.sv | 138 +++++++++++++
 tb/tb_fetch_sequencer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle between the sequencer, PC register, instruction memory and decode.
// FETCH_ALIGN_CHECK_EN adds the misalign_err status signal.
interface fetch_sequencer_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 32
) ();
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    pc_next;
  logic               imem_req;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic               halt;
  logic               halted;
`ifdef FETCH_ALIGN_CHECK_EN
  logic               misalign_err;
`endif

  // The sequencer is the master; PC register, memory and decode form the slave side.
  modport master (
    input  pc, imem_ack, imem_rdata, instr_ready, redirect, redirect_pc, halt,
    output pc_next, imem_req, instr, instr_valid, halted
`ifdef FETCH_ALIGN_CHECK_EN
    , output misalign_err
`endif
  );

  modport slave (
    output pc, imem_ack, imem_rdata, instr_ready, redirect, redirect_pc, halt,
    input  pc_next, imem_req, instr, instr_valid, halted
`ifdef FETCH_ALIGN_CHECK_EN
    , input misalign_err
`endif
  );
endinterface

// File: rtl/fetch_sequencer.sv
// PC-load and instruction-fetch sequencer: imem req/ack on one side, valid/ready to decode.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirects halt and raise a sticky misalign_err.
module fetch_sequencer #(
  parameter int              PC_W     = 8,
  parameter int              INSTR_W  = 32,
  parameter int              PC_STEP  = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  fetch_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_DRAIN,
    S_HALTED
  } state_t;

  state_t             r_state;
  logic               r_imem_req;
  logic               r_instr_valid;
  logic               r_halted;
  logic [INSTR_W-1:0] r_instr;

  logic               w_redirect;
  logic               w_misalign;
  logic               w_accept;
  logic [PC_W-1:0]    w_redirect_target;
  logic [PC_W-1:0]    w_pc_next;

  assign w_redirect        = bus.redirect && (r_state != S_IDLE);
  assign w_accept          = (r_state == S_HOLD) && bus.instr_ready;
  assign w_redirect_target = {bus.redirect_pc[PC_W-1:2], 2'b00};

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_misalign_err;
  assign w_misalign       = w_redirect && (bus.redirect_pc[1:0] != 2'b00);
  assign bus.misalign_err = r_misalign_err;
`else
  // Low target bits are simply dropped when the alignment check is not built in.
  logic w_unused_align_bits;
  assign w_unused_align_bits = ^bus.redirect_pc[1:0];
  assign w_misalign          = 1'b0;
`endif

  // NOTE: every path through always_comb assigns w_pc_next, starting with a default,
  // so no latch can be inferred when a branch is added later.
  always_comb begin
    w_pc_next = bus.pc;
    if (rst) begin
      w_pc_next = RESET_PC;
    end else if (w_redirect) begin
      w_pc_next = w_misalign ? bus.pc : w_redirect_target;
    end else if (w_accept) begin
      w_pc_next = bus.pc + PC_W'(PC_STEP);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
      r_instr       <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      r_misalign_err <= 1'b0;
`endif
    end else if (r_state == S_IDLE) begin
      r_state    <= S_FETCH;
      r_imem_req <= 1'b1;
    end else if (w_redirect) begin
      // Redirect wins over the handshake and halt; any word held for decode is dropped.
      r_instr_valid <= 1'b0;
      if (w_misalign) begin
        r_state    <= S_HALTED;
        r_imem_req <= 1'b0;
        r_halted   <= 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
        r_misalign_err <= 1'b1;
`endif
      end else if ((r_state == S_FETCH || r_state == S_DRAIN) && !bus.imem_ack) begin
        // A request is still in flight; its data must be swallowed before refetching.
        r_state    <= S_DRAIN;
        r_imem_req <= 1'b0;
        r_halted   <= 1'b0;
      end else begin
        r_state    <= S_FETCH;
        r_imem_req <= 1'b1;
        r_halted   <= 1'b0;
      end
    end else begin
      case (r_state)
        S_FETCH: begin
          if (bus.imem_ack) begin
            r_instr       <= bus.imem_rdata;
            r_instr_valid <= 1'b1;
            r_imem_req    <= 1'b0;
            r_state       <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (bus.instr_ready) begin
            r_instr_valid <= 1'b0;
            if (bus.halt) begin
              r_state  <= S_HALTED;
              r_halted <= 1'b1;
            end else begin
              r_state    <= S_FETCH;
              r_imem_req <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (bus.imem_ack) begin
            r_state    <= S_FETCH;
            r_imem_req <= 1'b1;
          end
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

  assign bus.pc_next     = w_pc_next;
  assign bus.imem_req    = r_imem_req;
  assign bus.instr       = r_instr;
  assign bus.instr_valid = r_instr_valid;
  assign bus.halted      = r_halted;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: memory responder, PC register model, delivery monitor.
// Directed sequences cover reset, stalls, PC wrap, drain after redirect, halt and alignment.
module tb_fetch_sequencer;
  localparam int PC_W    = 8;
  localparam int INSTR_W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_sequencer_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

  fetch_sequencer #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .PC_STEP(4), .RESET_PC(8'h00)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // External PC register loaded from pc_next every cycle.
  always @(posedge clk) bus.pc <= bus.pc_next;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] word;
  } exp_t;

  exp_t exp_q[$];
  int   checks      = 0;
  int   failures    = 0;
  int   ack_delay   = 1;
  int   n_acks      = 0;
  int   n_delivered = 0;

  bit         m_pending = 1'b0;
  int         m_cnt     = 0;
  logic [7:0] m_addr    = 8'h00;

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {8'hC3, a, ~a, 8'h5A};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: latches the address when a request is first seen, acks ack_delay cycles later.
  initial begin
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'hDEADBEEF;
    forever begin
      @(negedge clk);
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = 32'hDEADBEEF;
      if (rst) begin
        m_pending = 1'b0;
      end else begin
        if (!m_pending && bus.imem_req) begin
          m_pending = 1'b1;
          m_addr    = bus.pc;
          m_cnt     = 0;
        end
        if (m_pending) begin
          if (m_cnt == ack_delay) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = mem_word(m_addr);
            m_pending      = 1'b0;
            n_acks++;
          end else begin
            m_cnt++;
          end
        end
      end
    end
  end

  // Monitor: every completed decode handshake must match the next expected word.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && bus.instr_valid && bus.instr_ready && !bus.redirect) begin
        exp_t e;
        n_delivered++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_delivery: got pc=%h instr=%h expected none", bus.pc, bus.instr);
        end else begin
          e = exp_q.pop_front();
          check("deliver_pc", {24'h0, bus.pc}, {24'h0, e.addr});
          check("deliver_instr", bus.instr, e.word);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic wait_valid(input string name);
    int n = 0;
    while (!bus.instr_valid) begin
      @(negedge clk);
      n++;
      if (n > 50) begin
        checks++;
        failures++;
        $display("FAIL %s_timeout: got instr_valid=0 expected 1 within 50 cycles", name);
        return;
      end
    end
  endtask

  task automatic accept(input logic [7:0] addr, input bit hlt = 1'b0);
    wait_valid("accept");
    exp_q.push_back('{addr, mem_word(addr)});
    bus.instr_ready = 1'b1;
    bus.halt        = hlt;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    bus.halt        = 1'b0;
  endtask

  task automatic redirect_to(input logic [7:0] target);
    bus.redirect    = 1'b1;
    bus.redirect_pc = target;
    @(negedge clk);
    bus.redirect    = 1'b0;
    #1;
  endtask

  initial begin
    int n_req;
    int n;
    rst             = 1'b1;
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 8'h00;
    bus.halt        = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'h0, bus.instr_valid}, 32'h0);
    check("rst_halted", {31'h0, bus.halted}, 32'h0);
    check("rst_req", {31'h0, bus.imem_req}, 32'h0);
    check("rst_pc_next", {24'h0, bus.pc_next}, 32'h00);
    check("rst_instr", bus.instr, 32'h0);
    rst = 1'b0;

    // Sequential fetch 00..0C, ack one cycle after each request
    ack_delay = 1;
    accept(8'h00);
    accept(8'h04);
    accept(8'h08);
    accept(8'h0C);

    // Slow memory: request held until ack at PC 10, stall decode two cycles with halt asserted
    ack_delay = 3;
    n_req = 0;
    n = 0;
    while (!bus.instr_valid && n < 50) begin
      if (bus.imem_req) n_req++;
      check("fetch_pc_stable", {24'h0, bus.pc}, 32'h10);
      @(negedge clk);
      n++;
    end
    check("req_high_cycles", n_req, 4);
    bus.halt = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("hold_valid", {31'h0, bus.instr_valid}, 32'h1);
      check("hold_req", {31'h0, bus.imem_req}, 32'h0);
      check("hold_pc", {24'h0, bus.pc}, 32'h10);
      @(negedge clk);
    end
    bus.halt  = 1'b0;
    ack_delay = 2;
    accept(8'h10);
    #3;
    check("no_double_fetch", n_acks, 5);
    check("halt_ignored", {31'h0, bus.halted}, 32'h0);

    // Redirect to 40 while the fetch at 14 is outstanding: drain and drop its data
    redirect_to(8'h40);
    check("drain_req", {31'h0, bus.imem_req}, 32'h0);
    check("drain_pc", {24'h0, bus.pc}, 32'h40);
    @(negedge clk);
    #1;
    check("drain_ack_req", {31'h0, bus.imem_req}, 32'h0);
    @(negedge clk);
    #1;
    check("refetch_req", {31'h0, bus.imem_req}, 32'h1);
    check("refetch_pc", {24'h0, bus.pc}, 32'h40);
    check("dropped_ack", n_acks, 6);

    // Redirect to FC in HOLD with ready high: word at 40 discarded; then wrap FC -> 00
    wait_valid("hold40");
    ack_delay       = 1;
    bus.instr_ready = 1'b1;
    redirect_to(8'hFC);
    bus.instr_ready = 1'b0;
    check("discard_valid", {31'h0, bus.instr_valid}, 32'h0);
    check("redir_fc_pc", {24'h0, bus.pc}, 32'hFC);
    wait_valid("holdfc");
    exp_q.push_back('{8'hFC, mem_word(8'hFC)});
    bus.instr_ready = 1'b1;
    #1;
    check("wrap_pc_next", {24'h0, bus.pc_next}, 32'h00);
    @(negedge clk);
    bus.instr_ready = 1'b0;
    #1;
    check("wrap_fetch_pc", {24'h0, bus.pc}, 32'h00);
    check("wrap_fetch_req", {31'h0, bus.imem_req}, 32'h1);

    // Halt with accept at PC 10, stay halted, redirect to 20 resumes
    wait_valid("hold00");
    redirect_to(8'h10);
    accept(8'h10, 1'b1);
    for (int i = 0; i < 10; i++) begin
      #1;
      check("halted", {31'h0, bus.halted}, 32'h1);
      check("halted_req", {31'h0, bus.imem_req}, 32'h0);
      check("halted_pc", {24'h0, bus.pc}, 32'h14);
      @(negedge clk);
    end
    redirect_to(8'h20);
    check("resume_halted", {31'h0, bus.halted}, 32'h0);
    check("resume_req", {31'h0, bus.imem_req}, 32'h1);
    check("resume_pc", {24'h0, bus.pc}, 32'h20);
    accept(8'h20);

    // Misaligned redirect target 42
    wait_valid("hold24");
`ifdef FETCH_ALIGN_CHECK_EN
    check("misalign_init", {31'h0, bus.misalign_err}, 32'h0);
    redirect_to(8'h42);
    check("misalign_err", {31'h0, bus.misalign_err}, 32'h1);
    check("misalign_halted", {31'h0, bus.halted}, 32'h1);
    check("misalign_pc", {24'h0, bus.pc}, 32'h24);
    check("misalign_req", {31'h0, bus.imem_req}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("misalign_rst", {31'h0, bus.misalign_err}, 32'h0);
    check("misalign_rst_halted", {31'h0, bus.halted}, 32'h0);
    check("misalign_rst_pc_next", {24'h0, bus.pc_next}, 32'h00);
    @(negedge clk);
    rst = 1'b0;
    accept(8'h00);
`else
    redirect_to(8'h42);
    check("align_clear_pc", {24'h0, bus.pc}, 32'h40);
    check("align_clear_req", {31'h0, bus.imem_req}, 32'h1);
    check("align_clear_halted", {31'h0, bus.halted}, 32'h0);
    accept(8'h40);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
